// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate checker: FSM encoding, mismatch mask layout, counter width.
package gate_check_pkg;

  localparam int CNT_W     = 8;
  localparam int MASK_NOT  = 0;
  localparam int MASK_NAND = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_checker_if.sv
// Stimulus, DUT-response and status bundle between the gate test harness and the checker.
interface gate_checker_if;
  import gate_check_pkg::*;

  logic             en;
  logic             clear;
  logic             in_not;
  logic             in1_nand;
  logic             in2_nand;
  logic             out_not;
  logic             out_nand;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [CNT_W-1:0] first_fail_idx;
  logic [1:0]       first_fail_mask;

  modport master (
    output en, clear, in_not, in1_nand, in2_nand, out_not, out_nand,
    input  busy, done, error, pass_count, fail_count, first_fail_idx, first_fail_mask
  );

  modport slave (
    input  en, clear, in_not, in1_nand, in2_nand, out_not, out_nand,
    output busy, done, error, pass_count, fail_count, first_fail_idx, first_fail_mask
  );

endinterface

// File: rtl/gate_check_delay.sv
// Valid-tagged delay line aligning {exp_nand, exp_not, valid} to the DUT latency.
module gate_check_delay #(
  parameter int LATENCY = 0
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       flush,
  input  logic [2:0] d_p0,
  output logic [2:0] q_pd
);

  if (LATENCY == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clk, reset_L, flush};
    assign q_pd = d_p0;
  end else begin : g_sr
    logic [2:0] sr_p [LATENCY];

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        for (int i = 0; i < LATENCY; i++) sr_p[i] <= '0;
      end else if (flush) begin
        for (int i = 0; i < LATENCY; i++) sr_p[i] <= '0;
      end else begin
        sr_p[0] <= d_p0;
        for (int i = 1; i < LATENCY; i++) sr_p[i] <= sr_p[i-1];
      end
    end

    assign q_pd = sr_p[LATENCY-1];
  end

endmodule

// File: rtl/gate_checker.sv
// Checks NOT/NAND DUT responses against locally computed expectations and
// keeps pass/fail statistics plus the first-failure record for one session.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int LATENCY     = 0,
  parameter int NUM_VECTORS = 4
) (
  input logic           clk,
  input logic           reset_L,
  gate_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] NV_LAST = CNT_W'(NUM_VECTORS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  logic             busy_q, done_q, error_q;
  logic [CNT_W-1:0] pass_q, fail_q, idx_q, ffi_q;
  logic [1:0]       ffm_q;

  // Stage 0: expectations from the stimulus sampled this edge
  logic run_p0, exp_not_p0, exp_nand_p0;
  assign run_p0      = (state == RUN);
  assign exp_not_p0  = ~bus.in_not;
  assign exp_nand_p0 = ~(bus.in1_nand & bus.in2_nand);

  logic       flush, cmp_fire, last_cmp, mis_not, mis_nand;
  logic [2:0] al_pd;
  logic       exp_not_pd, exp_nand_pd, vld_pd;

  gate_check_delay #(.LATENCY(LATENCY)) u_delay (
    .clk     (clk),
    .reset_L (reset_L),
    .flush   (flush),
    .d_p0    ({exp_nand_p0, exp_not_p0, run_p0}),
    .q_pd    (al_pd)
  );

  // Aligned stage: expectation now lines up with the DUT response
  assign {exp_nand_pd, exp_not_pd, vld_pd} = al_pd;
  assign mis_not  = exp_not_pd ^ bus.out_not;
  assign mis_nand = exp_nand_pd ^ bus.out_nand;
  assign cmp_fire = run_p0 & vld_pd & (idx_q <= NV_LAST);
  assign last_cmp = cmp_fire & (idx_q == NV_LAST);
  // Anything in flight is dropped whenever the session leaves RUN
  assign flush    = bus.clear | (run_p0 & (last_cmp | ~bus.en));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      ffi_q   <= '0;
      ffm_q   <= '0;
    end else if (bus.clear) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      ffi_q   <= '0;
      ffm_q   <= '0;
    end else begin
      if (cmp_fire) begin
        idx_q <= idx_q + CNT_W'(1);
        if (mis_not | mis_nand) begin
          fail_q  <= sat_inc(fail_q);
          error_q <= 1'b1;
          if (!error_q) begin
            ffi_q            <= idx_q;
            ffm_q[MASK_NOT]  <= mis_not;
            ffm_q[MASK_NAND] <= mis_nand;
          end
        end else begin
          pass_q <= sat_inc(pass_q);
        end
      end
      case (state)
        IDLE: if (bus.en) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end
        RUN: if (last_cmp) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (!bus.en) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        DONE: state <= DONE;
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.pass_count      = pass_q;
  assign bus.fail_count      = fail_q;
  assign bus.first_fail_idx  = ffi_q;
  assign bus.first_fail_mask = ffm_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: zero-latency, two-cycle-latency and saturation instances.
module tb_gate_checker;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  gate_checker_if bus0 ();
  gate_checker_if bus2 ();
  gate_checker_if buss ();

  gate_checker #(.LATENCY(0), .NUM_VECTORS(4))   u_l0  (.clk(clk), .reset_L(reset_L), .bus(bus0));
  gate_checker #(.LATENCY(2), .NUM_VECTORS(4))   u_l2  (.clk(clk), .reset_L(reset_L), .bus(bus2));
  gate_checker #(.LATENCY(0), .NUM_VECTORS(255)) u_sat (.clk(clk), .reset_L(reset_L), .bus(buss));

  // status word: {busy, done, error, pass, fail, first_fail_idx, first_fail_mask}
  logic [28:0] st0, st2, sts;
  assign st0 = {bus0.busy, bus0.done, bus0.error, bus0.pass_count, bus0.fail_count,
                bus0.first_fail_idx, bus0.first_fail_mask};
  assign st2 = {bus2.busy, bus2.done, bus2.error, bus2.pass_count, bus2.fail_count,
                bus2.first_fail_idx, bus2.first_fail_mask};
  assign sts = {buss.busy, buss.done, buss.error, buss.pass_count, buss.fail_count,
                buss.first_fail_idx, buss.first_fail_mask};

  // stimulus {in_not, in1_nand, in2_nand} for the latency scenario
  logic [2:0] vt [6] = '{3'b001, 3'b110, 3'b111, 3'b000, 3'b001, 3'b110};

  function automatic logic [28:0] stat(input logic b, input logic d, input logic e,
                                       input logic [7:0] p, input logic [7:0] f,
                                       input logic [7:0] i, input logic [1:0] m);
    return {b, d, e, p, f, i, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic n, input logic a, input logic b,
                        input logic bad_not, input logic bad_nand);
    bus0.in_not   = n;
    bus0.in1_nand = a;
    bus0.in2_nand = b;
    bus0.out_not  = ~n ^ bad_not;
    bus0.out_nand = ~(a & b) ^ bad_nand;
  endtask

  task automatic test_reset();
    logic [28:0] e;
    repeat (2) tick();
    e = '0;
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL reset_l0 got=%h exp=%h", st0, e); end
    n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL reset_l2 got=%h exp=%h", st2, e); end
    n_vec++; if (sts !== e) begin n_miss++; $display("FAIL reset_sat got=%h exp=%h", sts, e); end
    reset_L = 1'b1;
    tick();
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL idle_no_en got=%h exp=%h", st0, e); end
  endtask

  task automatic test_basic();
    logic [28:0] e;
    bus0.en = 1'b1;
    drive0(0, 0, 0, 0, 0);
    tick();
    e = stat(1, 0, 0, 0, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL basic_entry got=%h exp=%h", st0, e); end
    for (int k = 0; k < 4; k++) begin
      drive0(k[0], k[0], ~k[0], 0, 0);
      tick();
      if (k == 1) begin
        e = stat(1, 0, 0, 2, 0, 0, 2'b00);
        n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL basic_mid got=%h exp=%h", st0, e); end
      end
    end
    e = stat(0, 1, 0, 4, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL basic_done got=%h exp=%h", st0, e); end
    tick();
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL basic_hold got=%h exp=%h", st0, e); end
  endtask

  task automatic test_clear();
    logic [28:0] e;
    bus0.en = 1'b0;
    bus0.clear = 1'b1;
    tick();
    e = '0;
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL clear_in_done got=%h exp=%h", st0, e); end
    bus0.clear = 1'b0;
    bus0.en = 1'b1;
    drive0(0, 1, 1, 0, 0);
    tick();
    tick();
    e = stat(1, 0, 0, 1, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL clear_pre got=%h exp=%h", st0, e); end
    bus0.clear = 1'b1;
    drive0(0, 1, 1, 1, 0);
    tick();
    e = '0;
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL clear_mid_run got=%h exp=%h", st0, e); end
    bus0.clear = 1'b0;
    drive0(0, 1, 1, 0, 0);
    tick();
    e = stat(1, 0, 0, 0, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL clear_restart got=%h exp=%h", st0, e); end
    bus0.en = 1'b0;
    bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0;
  endtask

  task automatic test_fault();
    logic [28:0] e;
    logic [1:0]  ab [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    bus0.en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      // NAND output stuck at 1
      drive0(k[0], ab[k][1], ab[k][0], 0, ab[k][1] & ab[k][0]);
      tick();
      if (k == 2) begin
        e = stat(1, 0, 1, 2, 1, 2, 2'b10);
        n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL fault_first got=%h exp=%h", st0, e); end
      end
    end
    e = stat(0, 1, 1, 3, 1, 2, 2'b10);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL fault_done got=%h exp=%h", st0, e); end
    bus0.en = 1'b0;
    bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0;
  endtask

  task automatic test_abort();
    logic [28:0] e;
    bus0.en = 1'b1;
    drive0(1, 0, 1, 0, 0);
    tick();
    tick();
    bus0.en = 1'b0;
    tick();
    e = stat(0, 0, 0, 2, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL abort_idle got=%h exp=%h", st0, e); end
    tick();
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL abort_hold got=%h exp=%h", st0, e); end
    bus0.en = 1'b1;
    tick();
    e = stat(1, 0, 0, 2, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL abort_resume got=%h exp=%h", st0, e); end
    drive0(1, 0, 1, 0, 1);
    tick();
    e = stat(1, 0, 1, 2, 1, 2, 2'b10);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL abort_idx got=%h exp=%h", st0, e); end
    drive0(1, 0, 1, 0, 0);
    tick();
    e = stat(0, 1, 1, 3, 1, 2, 2'b10);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL abort_done got=%h exp=%h", st0, e); end
    bus0.en = 1'b0;
    bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0;
  endtask

  task automatic test_latency();
    logic [28:0] e;
    logic [2:0]  pv;
    // DUT model delayed by two cycles
    bus2.en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      pv = 3'b000;
      if (k >= 2) pv = vt[k-2];
      {bus2.in_not, bus2.in1_nand, bus2.in2_nand} = vt[k];
      bus2.out_not  = ~pv[2];
      bus2.out_nand = ~(pv[1] & pv[0]);
      tick();
      if (k == 1) begin
        e = stat(1, 0, 0, 0, 0, 0, 2'b00);
        n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL lat_no_cmp got=%h exp=%h", st2, e); end
      end
      if (k == 2) begin
        e = stat(1, 0, 0, 1, 0, 0, 2'b00);
        n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL lat_first got=%h exp=%h", st2, e); end
      end
      if (k == 4) begin
        e = stat(1, 0, 0, 3, 0, 0, 2'b00);
        n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL lat_not_done got=%h exp=%h", st2, e); end
      end
    end
    e = stat(0, 1, 0, 4, 0, 0, 2'b00);
    n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL lat_done got=%h exp=%h", st2, e); end
    // Same stimulus, zero-delay DUT
    bus2.en = 1'b0;
    bus2.clear = 1'b1;
    tick();
    bus2.clear = 1'b0;
    bus2.en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      {bus2.in_not, bus2.in1_nand, bus2.in2_nand} = vt[k];
      bus2.out_not  = ~vt[k][2];
      bus2.out_nand = ~(vt[k][1] & vt[k][0]);
      tick();
    end
    e = stat(0, 1, 1, 0, 4, 0, 2'b11);
    n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL lat_zero_delay_dut got=%h exp=%h", st2, e); end
  endtask

  task automatic test_async_reset();
    logic [28:0] e;
    bus0.en = 1'b1;
    drive0(0, 1, 0, 0, 0);
    tick();
    tick();
    e = stat(1, 0, 0, 1, 0, 0, 2'b00);
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL areset_pre got=%h exp=%h", st0, e); end
    #2;
    reset_L = 1'b0;
    #1;
    e = '0;
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL areset_l0 got=%h exp=%h", st0, e); end
    n_vec++; if (st2 !== e) begin n_miss++; $display("FAIL areset_l2 got=%h exp=%h", st2, e); end
    bus0.en = 1'b0;
    bus2.en = 1'b0;
    #2;
    reset_L = 1'b1;
    tick();
    n_vec++; if (st0 !== e) begin n_miss++; $display("FAIL areset_after got=%h exp=%h", st0, e); end
  endtask

  task automatic test_saturation();
    logic [28:0] e;
    buss.in_not   = 1'b0;
    buss.out_not  = 1'b0;
    buss.in1_nand = 1'b0;
    buss.in2_nand = 1'b0;
    buss.out_nand = 1'b1;
    buss.en = 1'b1;
    tick();
    repeat (100) tick();
    e = stat(1, 0, 1, 0, 100, 0, 2'b01);
    n_vec++; if (sts !== e) begin n_miss++; $display("FAIL sat_mid got=%h exp=%h", sts, e); end
    repeat (200) tick();
    e = stat(0, 1, 1, 0, 255, 0, 2'b01);
    n_vec++; if (sts !== e) begin n_miss++; $display("FAIL sat_final got=%h exp=%h", sts, e); end
  endtask

  initial begin
    {bus0.en, bus0.clear, bus0.in_not, bus0.in1_nand, bus0.in2_nand, bus0.out_not, bus0.out_nand} = '0;
    {bus2.en, bus2.clear, bus2.in_not, bus2.in1_nand, bus2.in2_nand, bus2.out_not, bus2.out_nand} = '0;
    {buss.en, buss.clear, buss.in_not, buss.in1_nand, buss.in2_nand, buss.out_not, buss.out_nand} = '0;
    test_reset();
    test_basic();
    test_clear();
    test_fault();
    test_abort();
    test_latency();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
